// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - Y86-64 shared constants, encodings and condition helper for the execute stage
package execute_stage_pkg;

  localparam int STAT_W  = 3;
  localparam int ICODE_W = 4;
  localparam int IFUN_W  = 4;
  localparam int REG_W   = 4;

  typedef enum logic [ICODE_W-1:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  typedef enum logic [IFUN_W-1:0] {
    ALUADD = 4'h0,
    ALUSUB = 4'h1,
    ALUAND = 4'h2,
    ALUXOR = 4'h3,
    ALUMUL = 4'h4
  } alu_fun_e;

  typedef enum logic [IFUN_W-1:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } cond_e;

  localparam logic [STAT_W-1:0] SAOK = 3'd1;
  localparam logic [STAT_W-1:0] SADR = 3'd2;
  localparam logic [STAT_W-1:0] SINS = 3'd3;
  localparam logic [STAT_W-1:0] SHLT = 3'd4;

  localparam logic [REG_W-1:0] NREG = 4'hF;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // cc is packed {ZF,SF,OF}; unknown condition codes never fire
  function automatic logic cond_eval(input logic [2:0] cc, input logic [IFUN_W-1:0] fun);
    logic zf;
    logic sf;
    logic of;
    {zf, sf, of} = cc;
    case (fun)
      C_YES:   return 1'b1;
      C_LE:    return (sf ^ of) | zf;
      C_L:     return sf ^ of;
      C_E:     return zf;
      C_NE:    return ~zf;
      C_GE:    return ~(sf ^ of);
      C_G:     return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_mul_iter.sv
// rtl/execute_stage_mul_iter.sv - iterative shift-add multiplier FSM, built only with EXEC_MUL_EN
`ifdef EXEC_MUL_EN
module exec_mul_iter
  import execute_stage_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MUL_STEP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int STEPS = DATA_W / MUL_STEP_W;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  mul_state_e              state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_W-1:0]       acc;
  logic [MUL_STEP_W-1:0]   chunk;
  logic [DATA_W-1:0]       partial;
  int unsigned             shamt;

  // One MUL_STEP_W slice of b times a, aligned to its weight; bits above DATA_W drop out
  always_comb begin
    shamt   = int'(cnt) * MUL_STEP_W;
    chunk   = MUL_STEP_W'(b_i >> shamt);
    partial = (a_i * DATA_W'(chunk)) << shamt;
  end

  // Next state and handshake; a flush (valid_i dropping) abandons the product
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      MUL_IDLE: begin
        busy_o = valid_i;
        if (valid_i) state_nxt = MUL_BUSY;
      end
      MUL_BUSY: begin
        busy_o = valid_i;
        if (!valid_i)          state_nxt = MUL_IDLE;
        else if (cnt == LAST)  state_nxt = MUL_DONE;
      end
      MUL_DONE: begin
        done_o    = 1'b1;
        state_nxt = MUL_IDLE;
      end
      default: state_nxt = MUL_IDLE;
    endcase
  end

  assign product_o = acc;

  // State, step counter and accumulator
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= MUL_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (state == MUL_IDLE && valid_i) begin
        cnt <= '0;
        acc <= '0;
      end else if (state == MUL_BUSY && valid_i) begin
        cnt <= cnt + CNT_W'(1);
        acc <= acc + partial;
      end
    end
  end

endmodule
`endif

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage (ALU, CC register, condition, cmov dstE); EXEC_MUL_EN adds iterative MUL
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MUL_STEP_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [STAT_W-1:0]  E_stat_i,
  input  logic [ICODE_W-1:0] E_icode_i,
  input  logic [IFUN_W-1:0]  E_ifun_i,
  input  logic [DATA_W-1:0]  E_valC_i,
  input  logic [DATA_W-1:0]  E_valA_i,
  input  logic [DATA_W-1:0]  E_valB_i,
  input  logic [REG_W-1:0]   E_dstE_i,
  input  logic [REG_W-1:0]   E_dstM_i,
  input  logic [STAT_W-1:0]  m_stat_i,
  input  logic [STAT_W-1:0]  W_stat_i,
  output logic [STAT_W-1:0]  e_stat_o,
  output logic [ICODE_W-1:0] e_icode_o,
  output logic [REG_W-1:0]   e_dstM_o,
  output logic [DATA_W-1:0]  e_valA_o,
  output logic [DATA_W-1:0]  e_valE_o,
  output logic [REG_W-1:0]   e_dstE_o,
  output logic               e_Cnd_o,
  output logic               e_busy_o,
  output logic [2:0]         cc_o
);

  localparam int MSB = DATA_W - 1;

  if ((DATA_W % MUL_STEP_W) != 0) begin : g_step_check
    $error("MUL_STEP_W must divide DATA_W");
  end

  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [IFUN_W-1:0] alu_fun;
  logic              alu_of;
  logic              is_mul, stat_ok, set_cc;
  logic [2:0]        cc_q, cc_d;

  assign e_stat_o  = E_stat_i;
  assign e_icode_o = E_icode_i;
  assign e_dstM_o  = E_dstM_i;
  assign e_valA_o  = E_valA_i;
  assign cc_o      = cc_q;

  assign is_mul  = (E_icode_i == IOPQ) && (E_ifun_i == ALUMUL);
  assign alu_fun = (E_icode_i == IOPQ) ? E_ifun_i : ALUADD;
  assign stat_ok = (E_stat_i == SAOK) && (m_stat_i == SAOK) && (W_stat_i == SAOK);

  // Operand A: register, immediate/displacement, or the stack-pointer step
  always_comb begin
    alu_a = '0;
    case (E_icode_i)
      IRRMOVQ, IOPQ:             alu_a = E_valA_i;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = E_valC_i;
      ICALL, IPUSHQ:             alu_a = -DATA_W'(8);
      IRET, IPOPQ:               alu_a = DATA_W'(8);
      default:                   alu_a = '0;
    endcase
  end

  // Operand B: base register for address/stack/arith forms, zero otherwise
  always_comb begin
    alu_b = '0;
    case (E_icode_i)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ: alu_b = E_valB_i;
      default:                                           alu_b = '0;
    endcase
  end

  // Single-cycle ALU; unlisted function codes yield zero with OF clear
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (alu_fun)
      ALUADD: begin
        alu_res = alu_b + alu_a;
        alu_of  = (alu_a[MSB] == alu_b[MSB]) && (alu_res[MSB] != alu_a[MSB]);
      end
      ALUSUB: begin
        alu_res = alu_b - alu_a;
        alu_of  = (alu_a[MSB] != alu_b[MSB]) && (alu_res[MSB] != alu_b[MSB]);
      end
      ALUAND:  alu_res = alu_b & alu_a;
      ALUXOR:  alu_res = alu_b ^ alu_a;
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic              mul_valid, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product;

  assign mul_valid = is_mul && (E_stat_i == SAOK);

  exec_mul_iter #(
    .DATA_W     (DATA_W),
    .MUL_STEP_W (MUL_STEP_W)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .valid_i   (mul_valid),
    .a_i       (alu_a),
    .b_i       (alu_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign e_busy_o = mul_busy;
  // MUL may only touch CC on its DONE cycle; OF is already clear from the ALU default
  assign set_cc   = (E_icode_i == IOPQ) && stat_ok && (!is_mul || mul_done);

  // Result mux: product is only exposed once the iteration has finished
  always_comb begin
    e_valE_o = alu_res;
    if (is_mul) e_valE_o = mul_done ? mul_product : '0;
  end
`else
  assign e_busy_o = 1'b0;
  // Without the multiplier, ifun 4 is inert: zero result and no flag update
  assign set_cc   = (E_icode_i == IOPQ) && stat_ok && !is_mul;

  // Result mux: ALU only
  always_comb begin
    e_valE_o = alu_res;
  end
`endif

  assign cc_d = {(e_valE_o == '0), e_valE_o[MSB], alu_of};

  // Condition uses the committed CC, not the flags being produced this cycle
  always_comb begin
    e_Cnd_o  = cond_eval(cc_q, E_ifun_i);
    e_dstE_o = E_dstE_i;
    if (E_icode_i == IRRMOVQ && !e_Cnd_o) e_dstE_o = NREG;
  end

  // Architectural condition codes {ZF,SF,OF}; never stalled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cc_q <= 3'b100;
    end else if (set_cc) begin
      cc_q <= cc_d;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed table-driven bench for execute_stage
module tb_execute_stage;
  import execute_stage_pkg::*;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, rst_n;
  logic [2:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode, e_dstM, e_dstE;
  logic [63:0] e_valA, e_valE;
  logic        e_Cnd, e_busy;
  logic [2:0]  cc;

  int checks = 0;
  int errors = 0;

  execute_stage #(.DATA_W(64), .MUL_STEP_W(8)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .E_stat_i  (E_stat),
    .E_icode_i (E_icode),
    .E_ifun_i  (E_ifun),
    .E_valC_i  (E_valC),
    .E_valA_i  (E_valA),
    .E_valB_i  (E_valB),
    .E_dstE_i  (E_dstE),
    .E_dstM_i  (E_dstM),
    .m_stat_i  (m_stat),
    .W_stat_i  (W_stat),
    .e_stat_o  (e_stat),
    .e_icode_o (e_icode),
    .e_dstM_o  (e_dstM),
    .e_valA_o  (e_valA),
    .e_valE_o  (e_valE),
    .e_dstE_o  (e_dstE),
    .e_Cnd_o   (e_Cnd),
    .e_busy_o  (e_busy),
    .cc_o      (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] va, vb, vc;
    logic [3:0]  dste;
    logic [2:0]  est, mst, wst;
    logic [63:0] x_vale;
    logic [3:0]  x_dste;
    logic        x_cnd;
    logic [2:0]  x_cc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                         input logic [3:0] dste, input logic [2:0] est, input logic [2:0] mst,
                         input logic [2:0] wst, input logic [63:0] x_vale, input logic [3:0] x_dste,
                         input logic x_cnd, input logic [2:0] x_cc);
    vec_t v;
    v.icode = icode; v.ifun = ifun; v.va = va; v.vb = vb; v.vc = vc; v.dste = dste;
    v.est = est; v.mst = mst; v.wst = wst;
    v.x_vale = x_vale; v.x_dste = x_dste; v.x_cnd = x_cnd; v.x_cc = x_cc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] dste, input logic [2:0] est, input logic [2:0] mst,
                       input logic [2:0] wst);
    E_icode = icode; E_ifun = ifun; E_valA = va; E_valB = vb; E_valC = vc;
    E_dstE = dste; E_dstM = 4'h7; E_stat = est; m_stat = mst; W_stat = wst;
  endtask

  task automatic drive_nop();
    drive(INOP, 4'h0, 64'h0, 64'h0, 64'h0, NREG, SAOK, SAOK, SAOK);
  endtask

`ifdef EXEC_MUL_EN
  task automatic mul_run(input logic [63:0] a, input logic [63:0] b,
                         output int nbusy, output logic [63:0] res);
    @(negedge clk);
    drive(IOPQ, ALUMUL, a, b, 64'h0, 4'h3, SAOK, SAOK, SAOK);
    nbusy = 0;
    #1;
    while (e_busy && nbusy < 30) begin
      nbusy++;
      @(negedge clk);
      #1;
    end
    res = e_valE;
  endtask
`endif

  initial begin
    // ins: icode ifun valA valB valC dstE E m W | exp: valE dstE Cnd cc-after-edge
    add_vec(IOPQ,    ALUADD, MAXP,  64'h1,   64'h0,   4'h3, SAOK, SAOK, SAOK, MINN,             4'h3, 1'b1, 3'b011);
    add_vec(IOPQ,    ALUSUB, 64'h5, 64'h5,   64'h0,   4'h3, SAOK, SAOK, SAOK, 64'h0,            4'h3, 1'b0, 3'b100);
    add_vec(IRRMOVQ, C_NE,   64'h1234, 64'h0, 64'h0,  4'h2, SAOK, SAOK, SAOK, 64'h1234,         NREG, 1'b0, 3'b100);
    add_vec(IRRMOVQ, C_E,    64'h55, 64'h0,  64'h0,   4'h2, SAOK, SAOK, SAOK, 64'h55,           4'h2, 1'b1, 3'b100);
    add_vec(IOPQ,    ALUADD, 64'h1, 64'h2,   64'h0,   4'h3, SAOK, SADR, SAOK, 64'h3,            4'h3, 1'b1, 3'b100);
    add_vec(IOPQ,    ALUSUB, 64'h1, 64'h2,   64'h0,   4'h3, SAOK, SAOK, SHLT, 64'h1,            4'h3, 1'b1, 3'b100);
    add_vec(IPUSHQ,  4'h0,   64'h9, 64'h100, 64'h0,   4'h4, SAOK, SAOK, SAOK, 64'hF8,           4'h4, 1'b1, 3'b100);
    add_vec(IRMMOVQ, 4'h0,   64'h9, 64'h200, 64'h8,   NREG, SAOK, SAOK, SAOK, 64'h208,          NREG, 1'b1, 3'b100);
    add_vec(IOPQ,    ALUXOR, 64'hFF, 64'h0F, 64'h0,   4'h1, SAOK, SAOK, SAOK, 64'hF0,           4'h1, 1'b1, 3'b000);
    add_vec(IJXX,    C_G,    64'h0, 64'h0,   64'h40,  NREG, SAOK, SAOK, SAOK, 64'h0,            NREG, 1'b1, 3'b000);
    add_vec(IOPQ,    ALUSUB, 64'h1, 64'h0,   64'h0,   4'h1, SAOK, SAOK, SAOK, ONES,             4'h1, 1'b0, 3'b010);
    add_vec(IJXX,    C_L,    64'h0, 64'h0,   64'h40,  NREG, SAOK, SAOK, SAOK, 64'h0,            NREG, 1'b1, 3'b010);
    add_vec(IJXX,    C_GE,   64'h0, 64'h0,   64'h40,  NREG, SAOK, SAOK, SAOK, 64'h0,            NREG, 1'b0, 3'b010);
    add_vec(IOPQ,    ALUSUB, 64'h1, MINN,    64'h0,   4'h1, SAOK, SAOK, SAOK, MAXP,             4'h1, 1'b1, 3'b001);
    add_vec(IJXX,    4'h7,   64'h0, 64'h0,   64'h40,  NREG, SAOK, SAOK, SAOK, 64'h0,            NREG, 1'b0, 3'b001);
    add_vec(IJXX,    C_LE,   64'h0, 64'h0,   64'h40,  NREG, SAOK, SAOK, SAOK, 64'h0,            NREG, 1'b1, 3'b001);
    add_vec(IPOPQ,   4'h0,   64'h9, 64'h100, 64'h0,   4'h4, SAOK, SAOK, SAOK, 64'h108,          4'h4, 1'b1, 3'b001);
    add_vec(ICALL,   4'h0,   64'h9, 64'h200, 64'h80,  4'h4, SAOK, SAOK, SAOK, 64'h1F8,          4'h4, 1'b1, 3'b001);
    add_vec(IRET,    4'h0,   64'h9, 64'h300, 64'h0,   4'h4, SAOK, SAOK, SAOK, 64'h308,          4'h4, 1'b1, 3'b001);
    add_vec(IMRMOVQ, 4'h0,   64'h9, 64'h20,  64'h10,  NREG, SAOK, SAOK, SAOK, 64'h30,           NREG, 1'b1, 3'b001);
    add_vec(IIRMOVQ, 4'h0,   64'h9, 64'h999, 64'hABC, 4'h5, SAOK, SAOK, SAOK, 64'hABC,          4'h5, 1'b1, 3'b001);
    add_vec(IOPQ,    ALUADD, 64'h1, 64'h1,   64'h0,   4'h3, SINS, SAOK, SAOK, 64'h2,            4'h3, 1'b1, 3'b001);
    add_vec(INOP,    4'h0,   64'h0, 64'h0,   64'h0,   NREG, SAOK, SAOK, SAOK, 64'h0,            NREG, 1'b1, 3'b001);
    add_vec(IOPQ,    ALUAND, 64'hF0, 64'h0F, 64'h0,   4'h3, SAOK, SAOK, SAOK, 64'h0,            4'h3, 1'b1, 3'b100);
`ifndef EXEC_MUL_EN
    add_vec(IOPQ,    ALUMUL, 64'h3, 64'h5,   64'h0,   4'h3, SAOK, SAOK, SAOK, 64'h0,            4'h3, 1'b0, 3'b100);
`endif
    add_vec(IOPQ,    ALUADD, ONES,  ONES,    64'h0,   4'h3, SAOK, SAOK, SAOK, 64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 1'b1, 3'b010);
    add_vec(IOPQ,    ALUADD, MINN,  MINN,    64'h0,   4'h3, SAOK, SAOK, SAOK, 64'h0,            4'h3, 1'b1, 3'b101);

    rst_n = 1'b0;
    drive_nop();
    #12;
    chk("reset_cc", {61'h0, cc}, 64'h4);
    chk("reset_busy", {63'h0, e_busy}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].icode, vecs[i].ifun, vecs[i].va, vecs[i].vb, vecs[i].vc,
            vecs[i].dste, vecs[i].est, vecs[i].mst, vecs[i].wst);
      #1;
      chk($sformatf("v%0d valE", i), e_valE, vecs[i].x_vale);
      chk($sformatf("v%0d dstE", i), {60'h0, e_dstE}, {60'h0, vecs[i].x_dste});
      chk($sformatf("v%0d Cnd", i), {63'h0, e_Cnd}, {63'h0, vecs[i].x_cnd});
      chk($sformatf("v%0d pass", i), {53'h0, e_stat, e_icode, e_dstM},
          {53'h0, vecs[i].est, vecs[i].icode, 4'h7});
      chk($sformatf("v%0d valA", i), e_valA, vecs[i].va);
      chk($sformatf("v%0d busy", i), {63'h0, e_busy}, 64'h0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d cc", i), {61'h0, cc}, {61'h0, vecs[i].x_cc});
    end

    // asynchronous reset in the middle of a low clock phase
    @(negedge clk);
    drive_nop();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_cc", {61'h0, cc}, 64'h4);
    chk("async_reset_busy", {63'h0, e_busy}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef EXEC_MUL_EN
    begin
      int          nb;
      logic [63:0] r;
      mul_run(64'h3, 64'hFFFF_FFFF_FFFF_FFFB, nb, r);
      chk("mul_busy_cycles", 64'(nb), 64'd9);
      chk("mul_result", r, 64'hFFFF_FFFF_FFFF_FFF1);
      @(posedge clk);
      #1;
      chk("mul_cc", {61'h0, cc}, 64'h2);

      @(negedge clk);
      drive(IOPQ, ALUMUL, 64'h7, 64'h9, 64'h0, 4'h3, SAOK, SAOK, SAOK);
      #1;
      chk("flush_busy_start", {63'h0, e_busy}, 64'h1);
      repeat (3) @(negedge clk);
      drive_nop();
      @(posedge clk);
      #1;
      chk("flush_busy_drop", {63'h0, e_busy}, 64'h0);
      chk("flush_cc_hold", {61'h0, cc}, 64'h2);

      mul_run(ONES, ONES, nb, r);
      chk("mul2_busy_cycles", 64'(nb), 64'd9);
      chk("mul2_result", r, 64'h1);
      @(posedge clk);
      #1;
      chk("mul2_cc", {61'h0, cc}, 64'h0);
      @(negedge clk);
      drive_nop();
    end
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline execute stage, directly downstream of the E pipeline register; consumes its E_* outputs.
- Computes the ALU result (e_valE) and holds the architectural condition-code register (ZF/SF/OF).
- Evaluates the branch/cmov condition (e_Cnd) and resolves e_dstE for conditional moves.
- Feeds the M pipeline register, forwarding logic and hazard control.

Parameters:
- DATA_W, 64, datapath width; must match `DATA_BUS.
- MUL_STEP_W, 8, multiplier bits consumed per cycle; only used with EXEC_MUL_EN; must divide DATA_W.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous assert, active-low
- E_stat_i  in  `STAT_BUS  status from E reg
- E_icode_i  in  `ICODE_BUS  instruction code
- E_ifun_i  in  `IFUN_BUS  function code
- E_valC_i / E_valA_i / E_valB_i  in  `DATA_BUS  operands
- E_dstE_i / E_dstM_i  in  `REG_ADDR_BUS  destinations
- m_stat_i  in  `STAT_BUS  status of the instruction currently in memory stage
- W_stat_i  in  `STAT_BUS  status in write-back stage
- e_stat_o / e_icode_o / e_dstM_o / e_valA_o  out  as inputs  pass-through
- e_valE_o  out  `DATA_BUS  ALU result
- e_dstE_o  out  `REG_ADDR_BUS  resolved destination
- e_Cnd_o  out  1  condition result
- e_busy_o  out  1  multi-cycle op in progress (EXEC_MUL_EN only; otherwise tied 0)
- cc_o  out  3  {ZF,SF,OF} debug view

Behaviour:
- One clock domain: clk_i. Reset: asynchronous, active-low (rst_n_i).
- Reset state: CC = {ZF=1,SF=0,OF=0}; multiplier FSM in IDLE, accumulator 0.
- All e_* outputs are combinational from the E_* inputs and CC. They take no reset value of their own; with a bubble in E they read NOP/NREG.
- aluA selection:
  - valA for IRRMOVQ and IOPQ.
  - valC for IIRMOVQ, IRMMOVQ, IMRMOVQ.
  - -8 for ICALL and IPUSHQ.
  - +8 for IRET and IPOPQ.
  - 0 otherwise.
- aluB selection:
  - valB for IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ.
  - 0 otherwise.
- alufun = ifun for IOPQ, else ADD. ALU ops: 0 ADD B+A; 1 SUB B-A; 2 AND; 3 XOR. Arithmetic is modulo 2^64; no carry is kept.
- Flags:
  - ZF = (res==0); SF = res[63].
  - OF for ADD: A[63]==B[63] && res[63]!=A[63].
  - OF for SUB: A[63]!=B[63] && res[63]!=B[63].
  - OF = 0 for AND/XOR.
- set_cc = (E_icode==IOPQ) && m_stat_i==SAOK && W_stat_i==SAOK && E_stat_i==SAOK. CC loads at posedge when set_cc is 1; otherwise it holds.
- Condition by ifun:
  - 0 always 1.
  - 1 LE: (SF^OF)|ZF.
  - 2 L: SF^OF.
  - 3 E: ZF.
  - 4 NE: ~ZF.
  - 5 GE: ~(SF^OF).
  - 6 G: ~(SF^OF)&~ZF.
  - Other codes give 0.
  - Evaluated from the current CC register, not from this cycle's flags.
- e_dstE_o = NREG when E_icode==IRRMOVQ && !e_Cnd, else E_dstE_i.
- Stall and bubble: the CC register is never stalled. Exception suppression is done only through set_cc.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: OPq ifun 4 = MUL, low DATA_W bits of the product, computed by an iterative shift-add FSM.
  - States and transitions:
    - IDLE: a valid MUL in E (E_stat==SAOK) drives e_busy_o=1 and moves to BUSY with cnt=0.
    - BUSY: accumulate MUL_STEP_W bits per cycle; e_busy_o=1; at cnt==DATA_W/MUL_STEP_W-1 move to DONE.
    - DONE: e_busy_o=0; e_valE_o = product; set_cc is allowed (OF=0); return to IDLE.
  - Hazard control stalls E and bubbles M while e_busy_o=1.
  - If E_icode/ifun stops being MUL while in BUSY (flush), return to IDLE without updating CC.
  - Async reset mid-operation returns to IDLE.
  - Default latency: 9 busy cycles; the result is presented on the 10th cycle.
- Undefined: ifun 4 produces valE=0 and no CC update; e_busy_o=0; no FSM logic is synthesised.

Decomposition:
- define.v holds the shared constants: icodes, ALU fun codes (ALUADD/ALUSUB/ALUAND/ALUXOR/ALUMUL), condition codes, SAOK/SHLT/SADR/SINS, NREG, and the bus widths.
- Natural sub-module: exec_mul_iter (FSM + accumulator). It is instantiated only under EXEC_MUL_EN.

Test Plan:
- Reset: rst_n_i=0 asynchronously mid-cycle -> cc_o=3'b100, e_busy_o=0.
- ADD overflow: OPq ADD, valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> valE=0x8000_0000_0000_0000; next cycle cc_o={0,1,1}.
- SUB zero: SUB A=5, B=5 -> valE=0, ZF=1. Then cmovne (IRRMOVQ, ifun 4) -> e_Cnd=0, e_dstE=NREG.
- Exception suppression: OPq with m_stat_i=SADR -> CC unchanged. Same with W_stat_i=SHLT -> unchanged.
- Address/stack: IPUSHQ valB=0x100 -> valE=0xF8. IRMMOVQ valC=8, valB=0x200 -> valE=0x208. Neither changes CC.
- EXEC_MUL_EN: MUL A=3, B=-5 -> e_busy_o high 9 cycles, then valE=0xFFFF_FFFF_FFFF_FFF1 and SF=1. A bubble injected mid-BUSY -> IDLE, CC unchanged.
